scan_seq_3b: RTL
================

SCAN_SEQ_3B -- requirements
Module: scan_seq_3b

Interface
REQ-001 Parameter: DWELL_W, default 8, width of the dwell-time field.
REQ-002 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous reset, active-low.
REQ-004 Port: start  input  1  request a scan; accepted only in IDLE.
REQ-005 Port: stop  input  1  abort the scan; accepted in any state.
REQ-006 Port: cont  input  1  1 = continuous scanning, 0 = one-shot (8 channels); sampled at start.
REQ-007 Port: dwell  input  DWELL_W  cycles each channel is held active; sampled at start.
REQ-008 Port: a  output  3  channel select for the downstream 3-to-8 decoder.
REQ-009 Port: en  output  1  decoder enable; 1 only while a channel is active.
REQ-010 Port: busy  output  1  1 in any state other than IDLE.
REQ-011 Port: done  output  1  one-cycle pulse at the end of a completed one-shot scan.
REQ-012 Port: wrap  output  1  one-cycle pulse when continuous mode returns from channel 7 to channel 0.

Function
REQ-013 States: IDLE, ACTIVE and BLANK (BLANK exists only per REQ-027); all outputs registered.
REQ-014 IDLE: a=0, en=0, busy=0; done and wrap are 0 except for the pulse in REQ-019.
REQ-015 start=1 and stop=0 in IDLE: next cycle ACTIVE, a=0, en=1, busy=1; latch cont and dwell; load the dwell counter.
REQ-016 Effective dwell = max(dwell,1): dwell=0 behaves as 1, and dwell=N keeps each channel in ACTIVE for exactly N cycles.
REQ-017 dwell and cont changes while busy have no effect until the next accepted start.
REQ-018 End of ACTIVE with a<7: advance to channel a+1 (via BLANK when compiled in) and reload the dwell counter.
REQ-019 End of ACTIVE with a=7, one-shot: the next cycle is IDLE with a=0, en=0 and done=1 for that single cycle.
REQ-020 End of ACTIVE with a=7, continuous: wrap to channel 0, pulse wrap=1 for one cycle (the cycle a first shows 0), and do not pulse done.
REQ-021 stop=1 in any non-IDLE state: the next cycle is IDLE with a=0, en=0, and no done or wrap pulse.
REQ-022 start and stop together in IDLE: stop wins; remain IDLE.
REQ-023 start while busy is ignored and does not restart the scan.
REQ-024 en=1 never coincides with a change of a in the same cycle unless blanking is compiled out.

Reset
REQ-025 rst_n=0 forces IDLE immediately (asynchronously): a=0, en=0, busy=0, done=0, wrap=0, dwell counter=0.
REQ-026 Reset asserted mid-scan discards the latched cont and dwell; after release the block stays in IDLE until a new start.

Configuration
REQ-027 Macro SCAN_SEQ_BLANK_EN defined: between consecutive channels (including the 7-to-0 wrap) insert one BLANK cycle with en=0 and a already set to the next channel; the next ACTIVE follows with en=1.
REQ-028 SCAN_SEQ_BLANK_EN undefined: there is no BLANK state; a advances directly with en held at 1, and the channel period is exactly the effective dwell.

Verification
REQ-029 Reset mid-scan (a=3): all outputs 0 at once; start accepted again after release.
REQ-030 One-shot, dwell=2, blanking off: start -> en=1 for 16 cycles, a = 0,0,1,1,...,7,7; then done=1 for one cycle, busy=0.
REQ-031 One-shot, dwell=0, blanking on: each channel has 1 cycle with en=1 followed by 1 blank cycle; done follows the active cycle of channel 7.
REQ-032 Continuous, dwell=3: wrap=1 exactly once every 24 cycles (blanking off), with no done pulse; stop during a=5 -> IDLE next cycle, en=0.
REQ-033 start+stop in the same IDLE cycle -> remains IDLE; start pulsed again at a=4 -> ignored, sequence continues to a=5.
REQ-034 dwell changed from 2 to 7 mid-scan -> remaining channels still hold 2 cycles.

Source files
------------

// File: rtl/scan_seq_3b.sv
// 3-bit channel scan sequencer driving a 3-to-8 decoder select/enable.
// Optional macro SCAN_SEQ_BLANK_EN inserts one disabled cycle between channels.
module scan_seq_3b #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         a,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;

    state_t             state_q, state_d;
    logic [2:0]         a_q, a_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wrap_q, wrap_d;
    logic               cont_q, cont_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] rld_q, rld_d;
    logic [DWELL_W-1:0] dwell_m1;

    // Counter holds remaining cycles minus one, so dwell=0 and dwell=1 both load 0.
    assign dwell_m1 = (dwell == '0) ? '0 : dwell - 1'b1;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        cont_d  = cont_q;
        cnt_d   = cnt_q;
        rld_d   = rld_q;
        case (state_q)
            IDLE: begin
                a_d    = 3'd0;
                en_d   = 1'b0;
                busy_d = 1'b0;
                if (start && !stop) begin
                    state_d = ACTIVE;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    cont_d  = cont;
                    rld_d   = dwell_m1;
                    cnt_d   = dwell_m1;
                end
            end
            ACTIVE: begin
                if (stop) begin
                    state_d = IDLE;
                    a_d     = 3'd0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (a_q == 3'd7 && !cont_q) begin
                    state_d = IDLE;
                    a_d     = 3'd0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    // 3-bit increment rolls 7 back to 0 for continuous mode.
                    a_d    = a_q + 3'd1;
                    wrap_d = (a_q == 3'd7);
                    cnt_d  = rld_q;
`ifdef SCAN_SEQ_BLANK_EN
                    state_d = BLANK;
                    en_d    = 1'b0;
`endif
                end
            end
`ifdef SCAN_SEQ_BLANK_EN
            BLANK: begin
                if (stop) begin
                    state_d = IDLE;
                    a_d     = 3'd0;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ACTIVE;
                    en_d    = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                a_d     = 3'd0;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 3'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            cont_q  <= 1'b0;
            cnt_q   <= '0;
            rld_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            cont_q  <= cont_d;
            cnt_q   <= cnt_d;
            rld_q   <= rld_d;
        end
    end

    assign a    = a_q;
    assign en   = en_q;
    assign busy = busy_q;
    assign done = done_q;
    assign wrap = wrap_q;

endmodule
